// File: rtl/enc8b10b_framer_pkg.sv
// enc8b10b_framer_pkg
// Shared constants for the 8b/10b framer: K-character symbol codes,
// the framer FSM state encoding and the CRC-8 generator polynomial.
// Optional feature macro used by the framer: ENC8B10B_FRAMER_CRC_EN.
package enc8b10b_framer_pkg;

    localparam logic [7:0] SYM_IDLE = 8'hBC;  // K28.5 comma
    localparam logic [7:0] SYM_SOF  = 8'hFB;  // K27.7
    localparam logic [7:0] SYM_EOF  = 8'hFD;  // K29.7
    localparam logic [7:0] SYM_FILL = 8'hF7;  // K23.7

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // ST_CRC is only reachable when the CRC feature is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_EOF  = 2'd3
    } state_e;

endpackage

// File: rtl/enc8b10b_framer_crc8.sv
// enc8b10b_framer_crc8
// Combinational one-byte CRC-8 update (MSB first, no reflection).
// Ports:
//   crc_i  [7:0]  current CRC register
//   data_i [7:0]  byte to fold in
//   crc_o  [7:0]  updated CRC
module enc8b10b_framer_crc8
    import enc8b10b_framer_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] c;

    always_comb begin
        c = crc_i ^ data_i;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/enc8b10b_framer.sv
// enc8b10b_framer
// Single-lane framer feeding an 8b/10b encoder. Wraps valid/ready packets
// in SOF/EOF K-characters, fills idle time with K28.5, enforces a minimum
// idle gap after EOF and emits FILL on source underrun. Everything advances
// only in cycles where tx_ready is high.
// Optional feature: define ENC8B10B_FRAMER_CRC_EN to append a CRC-8 byte
// (poly 0x07, init 0) after the last data byte of each packet.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_valid/s_ready     source handshake; s_data byte, s_last end of packet
//   tx_ready            downstream accepts a new symbol this cycle
//   enc_data/enc_k      registered symbol to the encoder
//   enc_en              encoder enable (high the cycle after a tx_ready cycle)
//   frame_cnt           EOFs emitted, wraps
module enc8b10b_framer
    import enc8b10b_framer_pkg::*;
#(
    parameter int IPG   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    input  logic             tx_ready,
    output logic [7:0]       enc_data,
    output logic             enc_k,
    output logic             enc_en,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [3:0]       IPG_L   = 4'(IPG);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]       data_q, data_d;
    logic             k_q, k_d;
    logic             en_q;

`ifdef ENC8B10B_FRAMER_CRC_EN
    logic [7:0] crc_q, crc_d, crc_nxt;

    enc8b10b_framer_crc8 u_crc8 (
        .crc_i  (crc_q),
        .data_i (s_data),
        .crc_o  (crc_nxt)
    );
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        fcnt_d  = fcnt_q;
        data_d  = data_q;
        k_d     = k_q;
        s_ready = 1'b0;
`ifdef ENC8B10B_FRAMER_CRC_EN
        crc_d   = crc_q;
`endif
        // With tx_ready low every _d equals its _q, so all state freezes.
        if (tx_ready) begin
            case (state_q)
                ST_IDLE: begin
                    data_d = SYM_IDLE;
                    k_d    = 1'b1;
                    if (gap_q == 4'd0 && s_valid) begin
                        data_d  = SYM_SOF;
                        state_d = ST_DATA;
`ifdef ENC8B10B_FRAMER_CRC_EN
                        crc_d   = 8'h00;
`endif
                    end else if (gap_q != 4'd0) begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                ST_DATA: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        data_d = s_data;
                        k_d    = 1'b0;
`ifdef ENC8B10B_FRAMER_CRC_EN
                        crc_d  = crc_nxt;
                        if (s_last) state_d = ST_CRC;
`else
                        if (s_last) state_d = ST_EOF;
`endif
                    end else begin
                        data_d = SYM_FILL;
                        k_d    = 1'b1;
                    end
                end
`ifdef ENC8B10B_FRAMER_CRC_EN
                ST_CRC: begin
                    data_d  = crc_q;
                    k_d     = 1'b0;
                    state_d = ST_EOF;
                end
`endif
                ST_EOF: begin
                    data_d  = SYM_EOF;
                    k_d     = 1'b1;
                    fcnt_d  = fcnt_q + CNT_ONE;
                    gap_d   = IPG_L;
                    state_d = ST_IDLE;
                end
                default: begin
                    data_d  = SYM_IDLE;
                    k_d     = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gap_q   <= 4'd0;
            fcnt_q  <= '0;
            data_q  <= SYM_IDLE;
            k_q     <= 1'b1;
            en_q    <= 1'b0;
`ifdef ENC8B10B_FRAMER_CRC_EN
            crc_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            data_q  <= data_d;
            k_q     <= k_d;
            en_q    <= tx_ready;
`ifdef ENC8B10B_FRAMER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign enc_data  = data_q;
    assign enc_k     = k_q;
    assign enc_en    = en_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: doc/enc8b10b_framer.md
# enc8b10b_framer

Byte-stream framer sitting directly upstream of the 8b/10b encoder in the transmit path; drives the encoder's `data_in`, `k_char` and `enable` inputs with a single byte lane. It accepts packets over a valid/ready handshake and wraps each one in start-of-frame and end-of-frame K-characters. It fills idle time with K28.5 commas, enforces a minimum inter-packet gap, and inserts a fill character on source underrun. Symbols advance only while the downstream serializer signals readiness.

## Interface
Parameters:
- `IPG`, default 2: minimum number of K28.5 idles emitted between EOF and the next SOF (0 to 15).
- `CNT_W`, default 16: width of the frame counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  source byte valid.
- `s_ready`  out  1  framer accepts source byte this cycle.
- `s_data`  in  8  source byte.
- `s_last`  in  1  byte is the last byte of the packet.
- `tx_ready`  in  1  downstream can take a new symbol this cycle.
- `enc_data`  out  8  byte to encoder `data_in`.
- `enc_k`  out  1  to encoder `k_char`.
- `enc_en`  out  1  to encoder `enable`.
- `frame_cnt`  out  CNT_W  count of EOFs emitted; wraps modulo 2^CNT_W.

## Operation
- Symbols: IDLE K28.5 = 0xBC, SOF K27.7 = 0xFB, EOF K29.7 = 0xFD, FILL K23.7 = 0xF7. All K symbols use `enc_k`=1. Data and CRC bytes use `enc_k`=0.
- FSM states: IDLE, DATA, CRC (present only with the macro), EOF. All transitions occur only in cycles where `tx_ready`=1.
- IDLE:
  - Emits 0xBC.
  - When `gap_cnt`==0 and `s_valid`=1, emits SOF instead and moves to DATA.
  - Otherwise, if `gap_cnt`>0, decrements `gap_cnt`.
- DATA:
  - `s_ready` = `tx_ready` (combinational). It is 0 in every other state.
  - On a handshake, emits `s_data` with k=0.
  - If `s_last`=1 on that handshake, moves to CRC (or to EOF when the macro is absent).
  - If `s_valid`=0, emits FILL and stays in DATA.
- EOF:
  - Emits 0xFD.
  - Increments `frame_cnt`.
  - Loads `gap_cnt`=IPG and moves to IDLE.
- A zero-length packet is not possible: every packet carries at least one data byte.
- When `tx_ready`=0: outputs hold their values, `enc_en` is 0 on the next cycle, no state or counter changes, and `s_ready`=0.
- Reset mid-packet: the frame is abandoned with no EOF emitted. After reset, the output resumes with idles.

## Timing
- Reset values:
  - `enc_data`=0xBC, `enc_k`=1, `enc_en`=0, `s_ready`=0, `frame_cnt`=0.
  - FSM in IDLE, `gap_cnt`=0, so SOF is allowed immediately after reset.
- Outputs are registered. A symbol decided in cycle t (with `tx_ready`=1) appears on `enc_data`/`enc_k` in cycle t+1, with `enc_en`=1 in t+1.
- A byte accepted in cycle t is output at t+1.
- Latency from the first `s_valid` in IDLE (gap expired) to SOF on the outputs: 1 cycle. The first data byte follows at +2.
- With IPG=2, back-to-back packets produce: … last, [CRC], 0xFD, 0xBC, 0xBC, 0xFB, first …
- `s_last` on a cycle without a handshake is ignored.

## Configuration
- `ENC8B10B_FRAMER_CRC_EN`:
  - When defined: a CRC-8 is computed over all data bytes of the packet (poly 0x07, init 0x00, MSB first, no reflection, no final XOR). The CRC register clears at SOF. The CRC state emits the CRC byte with k=0, then moves to EOF. `tx_ready`=0 stalls the CRC state like any other.
  - When undefined: there is no CRC state and no CRC logic, and DATA goes straight to EOF.

## Structure
- Package `enc8b10b_framer_pkg`: the four symbol constants, the FSM state enum, and the CRC-8 polynomial constant.
- Optional sub-module `enc8b10b_framer_crc8`: a combinational one-byte CRC-8 update, instantiated only under the macro.
- The framer module holds the FSM, `gap_cnt`, `frame_cnt` and the output registers.

## Test plan
- Reset then hold `s_valid`=0, `tx_ready`=1: expect `enc_en` 0 then 1, constant 0xBC with k=1, and `frame_cnt`=0.
- Send packet {0x01,0x02} with `tx_ready`=1, CRC off: expect FB(k), 01, 02, FD(k), then BC, and `frame_cnt`=1.
- Same packet with `ENC8B10B_FRAMER_CRC_EN`: expect FB, 01, 02, 1B, FD. A single byte 0x01 must yield CRC 0x07.
- Deassert `s_valid` for 2 cycles mid-packet: expect two F7(k) symbols between the data bytes and no data loss.
- Two back-to-back packets with IPG=2, with `s_valid` held high: expect exactly two BC symbols between FD and the next FB, and `s_ready`=0 during the gap.
- Drop `tx_ready` for 3 cycles mid-packet, then assert `rst_n`=0 mid-packet:
  - During the stall: `enc_en`=0 and outputs frozen.
  - After reset: BC with `enc_en`=0, and no FD emitted.
